// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock first-word-fall-through FIFO.
//
// Purpose: queues request/snoop opcodes in front of the L1 cache controller.
// The head entry is visible on data_o whenever empty_o is low; a pop in the
// same cycle removes it.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset (clears pointers, count, storage)
//   flush_i     synchronous clear of pointers and count (storage kept)
//   testmode_i  DFT hook, no functional effect
//   data_i      write data
//   push_i      write strobe, ignored while full_o
//   full_o      count == DEPTH
//   pop_i       remove strobe, ignored while empty_o
//   data_o      storage at the read pointer (qualify with empty_o)
//   usage_o     current count (only with FIFO_USAGE_EN defined)
//   empty_o     count == 0
//
// Configuration macro: FIFO_USAGE_EN adds the usage_o port.

module fifo_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       testmode_i,
    input  logic [DATA_WIDTH-1:0]      data_i,
    input  logic                       push_i,
    output logic                       full_o,
    input  logic                       pop_i,
    output logic [DATA_WIDTH-1:0]      data_o,
`ifdef FIFO_USAGE_EN
    output logic [$clog2(DEPTH):0]     usage_o,
`endif
    output logic                       empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    ptr_t                  rp_q, rp_d;
    ptr_t                  wp_q, wp_d;
    cnt_t                  count_q, count_d;
    logic                  push_eff;
    logic                  pop_eff;

    // testmode_i is kept on the boundary for DFT insertion only.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == ptr_t'(DEPTH - 1)) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

    assign full_o  = (count_q == cnt_t'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rp_q];
`ifdef FIFO_USAGE_EN
    assign usage_o = count_q;
`endif

    // Gates use the registered flags, so a push while full is dropped even if
    // a pop frees a slot at the same edge.
    assign push_eff = push_i & ~full_o;
    assign pop_eff  = pop_i & ~empty_o;

    always_comb begin
        mem_d   = mem_q;
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        if (flush_i) begin
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
        end else begin
            if (push_eff) begin
                mem_d[wp_q] = data_i;
                wp_d        = ptr_inc(wp_q);
            end
            if (pop_eff) begin
                rp_d = ptr_inc(rp_q);
            end
            if (push_eff && !pop_eff) begin
                count_d = count_q + cnt_t'(1);
            end else if (pop_eff && !push_eff) begin
                count_d = count_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// Testbench for fifo_buffer (DEPTH=8, DATA_WIDTH=4): directed steps followed by
// random traffic, checked against a queue-based reference model.

module tb_fifo_buffer;

    localparam int unsigned DW = 4;
    localparam int unsigned DP = 8;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          testmode;
    logic [DW-1:0] din;
    logic          push;
    logic          full;
    logic          pop;
    logic [DW-1:0] dout;
    logic          empty;
`ifdef FIFO_USAGE_EN
    logic [$clog2(DP):0] usage;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] model_q[$];
    int            peak_usage;

    fifo_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DP)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush),
        .testmode_i(testmode),
        .data_i    (din),
        .push_i    (push),
        .full_o    (full),
        .pop_i     (pop),
        .data_o    (dout),
`ifdef FIFO_USAGE_EN
        .usage_o   (usage),
`endif
        .empty_o   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all visible state against the model.
    task automatic check_model(input string tag);
        check_bit({tag, ".empty"}, empty, model_q.size() == 0);
        check_bit({tag, ".full"}, full, model_q.size() == DP);
        if (model_q.size() != 0) begin
            check_data({tag, ".data"}, dout, model_q[0]);
        end
`ifdef FIFO_USAGE_EN
        tests_run++;
        assert (int'(usage) === model_q.size()) else begin
            tests_failed++;
            $error("FAIL %s.usage: observed %0d expected %0d", tag, usage, model_q.size());
        end
`endif
    endtask

    // One clock: drive strobes, apply the model's rules at the edge, check at +1.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic q,
                        input logic f, input string tag);
        bit was_full;
        bit was_empty;
        push  = p;
        din   = d;
        pop   = q;
        flush = f;
        was_full  = (model_q.size() == DP);
        was_empty = (model_q.size() == 0);
        @(posedge clk);
        if (f) begin
            model_q.delete();
        end else begin
            if (q && !was_empty) void'(model_q.pop_front());
            if (p && !was_full) model_q.push_back(d);
        end
        if (model_q.size() > peak_usage) peak_usage = model_q.size();
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        testmode = 1'b0;
        din = '0;
        push = 1'b0;
        pop = 1'b0;
        peak_usage = 0;
        #12;
        check_bit("reset.empty", empty, 1'b1);
        check_bit("reset.full", full, 1'b0);
        check_data("reset.data", dout, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill 1..8, dropped 9th push, drain in order.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "fill");
        check_bit("fill.full8", full, 1'b1);
        step(1'b1, 4'hF, 1'b0, 1'b0, "fill.drop");
        for (int i = 1; i <= 8; i++) begin
            check_data("drain.order", dout, DW'(i));
            step(1'b0, '0, 1'b1, 1'b0, "drain");
        end
        check_bit("drain.empty8", empty, 1'b1);

        // Wrap-around: 5 in/out, then A..F across the wrap.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "wrap.push5");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, "wrap.pop5");
        peak_usage = 0;
        for (int i = 10; i <= 15; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "wrap.push");
        tests_run++;
        assert (peak_usage === 6) else begin
            tests_failed++;
            $error("FAIL wrap.peak: observed %0d expected 6", peak_usage);
        end
        for (int i = 10; i <= 15; i++) begin
            check_data("wrap.order", dout, DW'(i));
            step(1'b0, '0, 1'b1, 1'b0, "wrap.pop");
        end

        // Simultaneous push/pop: empty, half full, full.
        step(1'b1, 4'h3, 1'b1, 1'b0, "both.empty");
        check_data("both.empty.data", dout, 4'h3);
        for (int i = 4; i < 7; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "half.fill");
        step(1'b1, 4'h9, 1'b1, 1'b0, "both.half");
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 1), 1'b0, 1'b0, "both.tofull");
        check_bit("both.isfull", full, 1'b1);
        step(1'b1, 4'hE, 1'b1, 1'b0, "both.full");
        check_bit("both.full.notfull", full, 1'b0);
        while (model_q.size() != 0) step(1'b0, '0, 1'b1, 1'b0, "both.drain");

        // Flush with a concurrent push.
        for (int i = 0; i < 4; i++) step(1'b1, DW'(i + 8), 1'b0, 1'b0, "flush.fill");
        step(1'b1, 4'h5, 1'b0, 1'b1, "flush");
        check_bit("flush.empty", empty, 1'b1);

        // Underflow with testmode toggling, then a clean push/pop.
        for (int i = 0; i < 5; i++) begin
            testmode = ~testmode;
            step(1'b0, '0, 1'b1, 1'b0, "underflow");
        end
        testmode = 1'b0;
        step(1'b1, 4'h7, 1'b0, 1'b0, "after.push7");
        check_data("after.data7", dout, 4'h7);
        step(1'b0, '0, 1'b1, 1'b0, "after.pop7");

        // Async reset mid-stream with 3 entries held.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(i + 2), 1'b0, 1'b0, "rst.fill");
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        check_bit("rst.async.empty", empty, 1'b1);
        check_bit("rst.async.full", full, 1'b0);
        check_data("rst.async.data", dout, '0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0, "rst.pop");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            testmode = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 3), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
